spi_lis3dh_slave: RTL and testbench
===================================

# spi_lis3dh_slave

Synthesizable SPI responder emulating the LIS3DH register interface. It is the device-side counterpart to `spi_master` and a drop-in replacement for `lis3dh_stub` in benches and on FPGA loopback builds. It oversamples CSN/SCK/SDI in the `clk` domain, decodes a command byte, and serves reads and writes against a small register file. It supports standard 4-wire mode and the LIS3DH SIM=1 3-wire mode, where read data is returned on the SDI line.

## Interface
- `WHOAMI`, 8'h33: read-only value at address 0x0F.
- `CTRL1_RST`, 8'h07: reset value of register 0x20.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `csn`  in  1: SPI chip select, active low.
- `sck`  in  1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- `mosi`  in  1: SDI; master data, or bidirectional line input in 3-wire mode.
- `miso`  out  1: SDO data, 4-wire mode.
- `miso_oe`  out  1: SDO output enable.
- `mosi_out`  out  1: read data driven onto the SDI line in 3-wire mode.
- `mosi_oe`  out  1: SDI-line output enable; asserted only in 3-wire mode during the data phase of a read.
- `spi3w`  out  1: mirrors SIM, bit 0 of register 0x23.

## Operation
- Input capture: `csn`, `sck` and `mosi` each pass through a 2-flop synchronizer. SCK rise/fall are detected from synchronized samples.
- Frame format: MSB first.
  - Byte 0: bit7 RW (1 = read), bit6 MS (1 = auto-increment), bits5:0 address.
  - Bytes 1..n: data.
- Register map:
  - 0x0F: WHOAMI, read-only.
  - 0x20..0x27: R/W. Reset to 0x00, except 0x20, which resets to CTRL1_RST.
  - All other addresses read 0x00; writes to them are ignored.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronized CSN falling.
  - CMD -> DATA after 8 rising SCK edges; the command is latched.
  - DATA loops per byte.
  - Any state -> IDLE on synchronized CSN high.
- Bit counter: 3 bits, cleared on CSN falling. Shift register: 8 bits, sampled on SCK rise.
- Writes: the register is updated when the 8th bit of each data byte is sampled.
- Reads: the addressed byte is loaded into the output shifter at the completion of the command byte and at each subsequent byte boundary. The shifter shifts on SCK fall.
- Address advance: after each data byte the address increments (6-bit wrap, 0x3F -> 0x00) if MS=1; otherwise it stays unchanged.
- Output routing by mode:
  - SIM=0: data appears on `miso`; `miso_oe` is high whenever CSN is low; `mosi_oe`=0.
  - SIM=1: data appears on `mosi_out` with `mosi_oe`=1 during DATA of a read only; `miso_oe`=0.
- SIM takes effect for the next frame. A frame that writes SIM keeps its own mode until CSN rises.
- Abort: CSN rising mid-byte discards the partial byte. Completed bytes stay committed.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `mosi_out`=0, `mosi_oe`=0, `spi3w`=0. FSM is IDLE; registers take their map reset values.
- Reset asserted mid-frame: immediate return to reset state; the frame is ignored until CSN next falls after reset release.
- Input latency: 2 clk synchronizer plus 1 clk edge detect.
- Output update: `miso`/`mosi_out` update 3 clk after the SCK falling edge.
- Constraint: SCK high and low phases must each be at least 4 `clk` periods. CSN setup/hold relative to SCK must be at least 4 `clk` periods.
- First read bit: presented after the 8th SCK fall of the command byte, and valid before the 9th rise.
- Write visibility: a register write appears in the register and `spi3w` 1 clk after the 16th sampling edge, i.e. 4 clk after the SCK rise.
- Output enables: `miso_oe` follows the synchronized CSN (3 clk lag). Both output enables drop within 3 clk of CSN rising.
- Simultaneous CSN rise and final SCK rise in one sample: the CSN rise wins, and the byte is discarded.

## Test plan
- 4-wire WHOAMI: frame 0x8F00 with `spi_master` DIV_COEF 1 -> `miso` carries 0x33 in the data byte; `spi3w`=0.
- Write SIM: frame 0x2301 -> `spi3w`=1 after the frame. A following 0x8F00 returns 0x33 on `mosi_out` with `mosi_oe`=1 during data only, and `miso_oe`=0. Frame 0x2300 -> `spi3w`=0.
- Burst with auto-increment: write 0x60,0xAA,0xBB (0x20..0x21, MS=1); read 0xE0 + 3 bytes -> 0xAA, 0xBB, 0x00. Repeat with MS=0 -> 0xAA, 0xAA, 0xAA.
- Read-only/unmapped: write 0x0F55 then 0x3A66; reading back 0x8F and 0xBA returns 0x33 and 0x00.
- Abort: 0x2301 with CSN raised after 12 SCK -> 0x23 stays 0x00, `spi3w`=0. The next full frame decodes correctly.
- Reset mid-frame: assert `reset` during the data byte of 0x2307 -> all outputs return to reset values, 0x20 reads 0x07, and the following frame is handled normally.

Source files
------------

// File: rtl/spi_lis3dh_slave.sv
// rtl/spi_lis3dh_slave.sv - SPI responder emulating the LIS3DH register interface (4-wire and SIM=1 3-wire)
module spi_lis3dh_slave #(
    parameter logic [7:0] WHOAMI    = 8'h33,
    parameter logic [7:0] CTRL1_RST = 8'h07
) (
    input  logic clk,
    input  logic reset,
    input  logic csn,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic mosi_out,
    output logic mosi_oe,
    output logic spi3w
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t      state, state_nxt;
    logic [1:0]  csn_sync, sck_sync, mosi_sync;
    logic        csn_s, csn_d, sck_s, sck_d, sdi_s;
    logic        csn_fall, sck_rise, sck_fall, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte, tx_shift, rd_data;
    logic [5:0]  addr, addr_nxt, rd_addr;
    logic        cmd_rw, cmd_ms, frame_sim, sim_now, tx_bit;
    logic [7:0]  regs [0:7];

    // Synchronizers reset low so a CSN still held low after reset never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csn_sync  <= 2'b00;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            csn_d     <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[0], csn};
            sck_sync  <= {sck_sync[0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
            csn_d     <= csn_sync[1];
            sck_d     <= sck_sync[1];
        end
    end

    assign csn_s     = csn_sync[1];
    assign sck_s     = sck_sync[1];
    assign sdi_s     = mosi_sync[1];
    assign csn_fall  = csn_d & ~csn_s;
    assign sck_rise  = ~csn_s & sck_s & ~sck_d;
    assign sck_fall  = ~csn_s & ~sck_s & sck_d;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, sdi_s};
    assign addr_nxt  = cmd_ms ? addr + 6'd1 : addr;
    assign sim_now   = csn_fall ? regs[3][0] : frame_sim;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = CMD;
            CMD:     if (csn_s) state_nxt = IDLE;
                     else if (byte_done) state_nxt = DATA;
            DATA:    if (csn_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte to preload: the command's address at the end of the command byte, else the advanced address.
    always_comb begin
        rd_addr = (state == CMD) ? rx_byte[5:0] : addr_nxt;
        rd_data = 8'h00;
        if (rd_addr == 6'h0F)
            rd_data = WHOAMI;
        else if (rd_addr[5:3] == 3'b100)
            rd_data = regs[rd_addr[2:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'd0;
            tx_bit    <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_ms    <= 1'b0;
            addr      <= 6'd0;
            frame_sim <= 1'b0;
            miso_oe   <= 1'b0;
            mosi_oe   <= 1'b0;
        end else begin
            if (csn_fall) begin
                bit_cnt   <= 3'd0;
                tx_shift  <= 8'd0;
                frame_sim <= regs[3][0];
            end else if (sck_rise && state != IDLE) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
            end

            if (state == IDLE || csn_s) begin
                tx_bit <= 1'b0;
            end else if (sck_fall) begin
                tx_bit   <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (byte_done && state == CMD) begin
                {cmd_rw, cmd_ms, addr} <= rx_byte;
                if (rx_byte[7]) tx_shift <= rd_data;
            end else if (byte_done && state == DATA) begin
                addr <= addr_nxt;
                if (cmd_rw) tx_shift <= rd_data;
            end

            miso_oe <= ~csn_s & ((state != IDLE) | csn_fall) & ~sim_now;
            mosi_oe <= ~csn_s & (state == DATA) & cmd_rw & frame_sim;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            regs[0] <= CTRL1_RST;
        end else if (state == DATA && byte_done && !cmd_rw && addr[5:3] == 3'b100) begin
            regs[addr[2:0]] <= rx_byte;
        end
    end

    assign miso     = tx_bit & ~frame_sim;
    assign mosi_out = tx_bit & frame_sim;
    assign spi3w    = regs[3][0];
endmodule

// File: tb/tb_spi_lis3dh_slave.sv
// tb/tb_spi_lis3dh_slave.sv - directed plus randomized frames checked against a register-map model
module tb_spi_lis3dh_slave;
    logic clk = 1'b0;
    logic reset, csn, sck, mosi;
    logic miso, miso_oe, mosi_out, mosi_oe, spi3w;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx [0:15];
    logic [7:0] rx_miso [0:15];
    logic [7:0] rx_mosi [0:15];
    logic [7:0] exp_rx [0:15];
    logic [7:0] mem [0:63];
    logic       oe_bad;

    spi_lis3dh_slave dut (
        .clk(clk), .reset(reset), .csn(csn), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mosi_out(mosi_out), .mosi_oe(mosi_oe), .spi3w(spi3w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [5:0] a);
        if (a == 6'h0F) return 8'h33;
        if (a >= 6'h20 && a <= 6'h27) return mem[a];
        return 8'h00;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[6'h20] = 8'h07;
    endtask

    task automatic model_frame(input int bits_done);
        logic       rw, ms;
        logic [5:0] a;
        int         nfull;
        nfull = bits_done / 8;
        if (nfull >= 1) begin
            rw = tx[0][7];
            ms = tx[0][6];
            a  = tx[0][5:0];
            for (int k = 1; k < nfull; k++) begin
                if (rw) exp_rx[k] = mread(a);
                else if (a >= 6'h20 && a <= 6'h27) mem[a] = tx[k];
                if (ms) a = a + 6'd1;
            end
        end
    endtask

    task automatic xfer(input int nbytes, input int stop_bit, input bit csn_last,
                        input int reset_bit, input bit exp_sim, input bit is_rd);
        int total;
        total = (stop_bit > 0) ? stop_bit : nbytes * 8;
        oe_bad = 1'b0;
        csn = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < total; i++) begin
            if (reset_bit > 0 && i == reset_bit) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_miso", {7'd0, miso}, 8'd0);
                check("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
                check("rst_mosi_out", {7'd0, mosi_out}, 8'd0);
                check("rst_mosi_oe", {7'd0, mosi_oe}, 8'd0);
                check("rst_spi3w", {7'd0, spi3w}, 8'd0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
            mosi = tx[i / 8][7 - (i % 8)];
            repeat (5) @(negedge clk);
            rx_miso[i / 8][7 - (i % 8)] = miso;
            rx_mosi[i / 8][7 - (i % 8)] = mosi_out;
            if (reset_bit == 0 || i < reset_bit) begin
                if (mosi_oe !== (exp_sim && is_rd && i >= 8)) oe_bad = 1'b1;
                if (miso_oe !== !exp_sim) oe_bad = 1'b1;
            end
            sck = 1'b1;
            if (csn_last && i == total - 1) csn = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
        repeat (6) @(negedge clk);
        csn = 1'b1;
        repeat (3) @(negedge clk);
        check("oe_off_miso", {7'd0, miso_oe}, 8'd0);
        check("oe_off_mosi", {7'd0, mosi_oe}, 8'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic run(input string tag, input int nbytes, input int stop_bit,
                       input bit csn_last, input int reset_bit);
        bit sim0, is_rd;
        int bits_done;
        sim0  = mem[6'h23][0];
        is_rd = tx[0][7];
        xfer(nbytes, stop_bit, csn_last, reset_bit, sim0, is_rd);
        bits_done = (stop_bit > 0) ? stop_bit : nbytes * 8;
        if (csn_last) bits_done--;
        if (reset_bit > 0) mreset();
        else model_frame(bits_done);
        if (reset_bit == 0 && is_rd)
            for (int k = 1; k < bits_done / 8; k++)
                check($sformatf("%s:rd%0d", tag, k), sim0 ? rx_mosi[k] : rx_miso[k], exp_rx[k]);
        check({tag, ":oe"}, {7'd0, oe_bad}, 8'd0);
        check({tag, ":spi3w"}, {7'd0, spi3w}, {7'd0, mem[6'h23][0]});
    endtask

    initial begin
        int         n;
        logic [5:0] a;
        reset = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
        mreset();
        repeat (3) @(negedge clk);
        check("init_miso", {7'd0, miso}, 8'd0);
        check("init_miso_oe", {7'd0, miso_oe}, 8'd0);
        check("init_mosi_out", {7'd0, mosi_out}, 8'd0);
        check("init_mosi_oe", {7'd0, mosi_oe}, 8'd0);
        check("init_spi3w", {7'd0, spi3w}, 8'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        tx[0] = 8'h8F; tx[1] = 8'h00;                 run("whoami4", 2, 0, 0, 0);
        tx[0] = 8'h23; tx[1] = 8'h01;                 run("sim_on", 2, 0, 0, 0);
        check("sim_on_exp", {7'd0, spi3w}, 8'd1);
        tx[0] = 8'h8F; tx[1] = 8'h00;                 run("whoami3", 2, 0, 0, 0);
        tx[0] = 8'h23; tx[1] = 8'h00;                 run("sim_off", 2, 0, 0, 0);
        tx[0] = 8'h60; tx[1] = 8'hAA; tx[2] = 8'hBB;  run("burst_wr", 3, 0, 0, 0);
        tx[0] = 8'hE0; tx[1] = 0; tx[2] = 0; tx[3] = 0; run("burst_ms1", 4, 0, 0, 0);
        tx[0] = 8'hA0;                                run("burst_ms0", 4, 0, 0, 0);
        tx[0] = 8'h0F; tx[1] = 8'h55;                 run("wr_ro", 2, 0, 0, 0);
        tx[0] = 8'h3A; tx[1] = 8'h66;                 run("wr_unmap", 2, 0, 0, 0);
        tx[0] = 8'h8F; tx[1] = 8'h00;                 run("rd_ro", 2, 0, 0, 0);
        tx[0] = 8'hBA;                                run("rd_unmap", 2, 0, 0, 0);
        tx[0] = 8'h23; tx[1] = 8'h01;                 run("abort", 2, 12, 0, 0);
        tx[0] = 8'hA3; tx[1] = 8'h00;                 run("after_abort", 2, 0, 0, 0);
        tx[0] = 8'h21; tx[1] = 8'h5A;                 run("csn_race", 2, 0, 1, 0);
        tx[0] = 8'hA1; tx[1] = 8'h00;                 run("after_race", 2, 0, 0, 0);
        tx[0] = 8'hFF; tx[1] = 0; tx[2] = 0; tx[3] = 0; run("wrap", 4, 0, 0, 0);
        tx[0] = 8'h23; tx[1] = 8'h01;                 run("sim_on2", 2, 0, 0, 0);
        tx[0] = 8'h23; tx[1] = 8'h07;                 run("reset_mid", 2, 0, 0, 11);
        tx[0] = 8'hA0; tx[1] = 8'h00;                 run("after_reset", 2, 0, 0, 0);

        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(2, 5);
            case ($urandom_range(0, 3))
                0:       a = 6'h0F;
                1:       a = 6'($urandom);
                default: a = 6'h20 + 6'($urandom_range(0, 7));
            endcase
            tx[0] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a};
            for (int k = 1; k < n; k++) tx[k] = 8'($urandom);
            run($sformatf("rand%0d", it), n, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
